// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: counts 5-bit pattern hits in a 32-byte message held in data memory and writes back ctb/cto/cts
module pattern_scan_ctrl #(
  parameter int STR_BYTES = 32,
  parameter int PAT_ADDR  = 32,
  parameter int RES_ADDR  = 33,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          ack,
  output logic          busy,
  output logic [AW-1:0] dm_addr,
  input  logic [7:0]    dm_rd_data,
  output logic          dm_wr_en,
  output logic [7:0]    dm_wr_data
);
  typedef enum logic [2:0] {IDLE, RD_PAT, LD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE} state_t;
  state_t state;
  logic [4:0] pat;
  logic [3:0] prev;
  logic [7:0] ctb, cto, cts, ctb_n;
  logic [AW-1:0] idx;
  logic [11:0] win;
  logic [2:0] in_hits, x_hits;
  // win[j+:5] for j<4 are within-byte windows, j>=4 straddle the previous byte
  always_comb begin
    win = {prev, dm_rd_data};
    in_hits = '0;
    x_hits = '0;
    for (int j = 0; j < 4; j++) begin
      in_hits = in_hits + 3'(win[j+:5] == pat);
      x_hits = x_hits + 3'(win[j+4+:5] == pat && idx != '0);
    end
    ctb_n = ctb + 8'(in_hits);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ack <= 1'b0;
      busy <= 1'b0;
      dm_addr <= '0;
      dm_wr_en <= 1'b0;
      dm_wr_data <= '0;
      pat <= '0;
      prev <= '0;
      ctb <= '0;
      cto <= '0;
      cts <= '0;
      idx <= '0;
    end else begin
      dm_wr_en <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state <= RD_PAT;
          busy <= 1'b1;
          ack <= 1'b0;
          dm_addr <= AW'(PAT_ADDR);
          ctb <= '0;
          cto <= '0;
          cts <= '0;
          idx <= '0;
        end
        RD_PAT: begin
          state <= LD_PAT;
          dm_addr <= '0;
        end
        LD_PAT: begin
          state <= SCAN;
          pat <= dm_rd_data[4:0];
          dm_addr <= AW'(1);
        end
        SCAN: begin
          prev <= dm_rd_data[3:0];
          idx <= idx + 1'b1;
          dm_addr <= idx + AW'(2);
          ctb <= ctb_n;
          cto <= cto + 8'(in_hits != 3'd0);
          cts <= cts + 8'(in_hits) + 8'(x_hits);
          if (idx == AW'(STR_BYTES - 1)) begin
            state <= WR_CTB;
            dm_wr_en <= 1'b1;
            dm_addr <= AW'(RES_ADDR);
            dm_wr_data <= ctb_n;
          end
        end
        WR_CTB: begin
          state <= WR_CTO;
          dm_wr_en <= 1'b1;
          dm_addr <= AW'(RES_ADDR + 1);
          dm_wr_data <= cto;
        end
        WR_CTO: begin
          state <= WR_CTS;
          dm_wr_en <= 1'b1;
          dm_addr <= AW'(RES_ADDR + 2);
          dm_wr_data <= cts;
        end
        WR_CTS: begin
          state <= DONE;
          ack <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed bench with a synchronous-read memory model
module tb_pattern_scan_ctrl;
  logic clk = 0, reset = 1, start = 0;
  logic ack, busy, dm_wr_en;
  logic [7:0] dm_addr, dm_rd_data, dm_wr_data;
  logic [7:0] mem [256];
  logic ld = 0;
  logic [7:0] ld_addr = 0, ld_data = 0;
  int wr_cnt = 0, passed = 0, total = 0;
  pattern_scan_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .busy(busy),
    .dm_addr(dm_addr), .dm_rd_data(dm_rd_data), .dm_wr_en(dm_wr_en), .dm_wr_data(dm_wr_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    dm_rd_data <= mem[dm_addr];
    if (ld) mem[ld_addr] <= ld_data;
    else if (dm_wr_en) begin
      mem[dm_addr] <= dm_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld = 1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1 ld = 0;
  endtask
  task automatic fill(input logic [7:0] p, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] rest);
    load(8'd32, p);
    load(8'd0, b0);
    load(8'd1, b1);
    for (int i = 2; i < 32; i++) load(8'(i), rest);
  endtask
  // the clock whose edge samples start counts as clock 1
  task automatic run(input string tag, input int e_ctb, input int e_cto, input int e_cts, input int glitch);
    int cyc, w0;
    w0 = wr_cnt;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    cyc = 1;
    chk({tag, "_ack_low"}, ack, 0);
    chk({tag, "_busy"}, busy, 1);
    while (!ack && cyc < 100) begin
      start = (cyc == glitch);
      @(posedge clk);
      #1 cyc++;
    end
    start = 0;
    chk({tag, "_latency"}, cyc, 38);
    chk({tag, "_ctb"}, mem[33], e_ctb);
    chk({tag, "_cto"}, mem[34], e_cto);
    chk({tag, "_cts"}, mem[35], e_cts);
    chk({tag, "_writes"}, wr_cnt - w0, 3);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", dm_wr_en, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wr_data", dm_wr_data, 0);
    reset = 0;
    fill(8'h00, 8'h00, 8'h00, 8'h00);
    run("zeros", 128, 32, 252, 0);
    fill(8'h15, 8'h55, 8'h55, 8'h55);
    run("alt", 64, 32, 126, 0);
    fill(8'h1F, 8'h03, 8'hE0, 8'h00);
    run("cross", 0, 0, 1, 0);
    fill(8'h1F, 8'hFF, 8'hFF, 8'hFF);
    run("ones", 128, 32, 252, 0);
    fill(8'h1F, 8'h00, 8'h00, 8'h00);
    run("rerun", 0, 0, 0, 0);
    load(8'd33, 8'hA1);
    load(8'd34, 8'hA2);
    load(8'd35, 8'hA3);
    fill(8'h00, 8'h00, 8'h00, 8'h00);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (12) @(posedge clk);
    #2 reset = 1;
    #1;
    chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", dm_wr_en, 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("abort_mem33", mem[33], 8'hA1);
    chk("abort_mem34", mem[34], 8'hA2);
    chk("abort_mem35", mem[35], 8'hA3);
    run("after_rst", 128, 32, 252, 0);
    fill(8'h15, 8'h55, 8'h55, 8'h55);
    run("glitch", 64, 32, 126, 10);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
